// File: rtl/input_conditioner.sv
// input_conditioner: synchronize, debounce and edge/long-press detect raw inputs.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module input_conditioner #(
  parameter int WIDTH          = 8,
  parameter int TICK_CYCLES    = 100000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int LONG_TICKS     = 1000
) (
  input  logic             CLK100MHZ,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] RAW_IN,
  output logic [WIDTH-1:0] LEVEL,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] LONG,
  output logic [WIDTH-1:0] HELD,
  output logic             TICK
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign TICK = (pre_cnt == PRE_LAST);

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= RAW_IN;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          level_r;
    logic          rise_r;
    logic          fall_r;
    logic          long_r;
    logic          held_r;
    logic          accept;

    // The new value is accepted on the tick that would complete the debounce count.
    assign accept = (sync_b[i] != level_r) && TICK && (db_cnt == DB_LAST);

    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
      if (!RST_N) begin
        db_cnt   <= '0;
        hold_cnt <= '0;
        level_r  <= 1'b0;
        rise_r   <= 1'b0;
        fall_r   <= 1'b0;
        long_r   <= 1'b0;
        held_r   <= 1'b0;
      end else begin
        rise_r <= accept && !level_r;
        fall_r <= accept && level_r;
        long_r <= 1'b0;

        if ((sync_b[i] == level_r) || accept) begin
          db_cnt <= '0;
        end else if (TICK) begin
          db_cnt <= db_cnt + 1'b1;
        end

        if (accept) begin
          level_r <= !level_r;
        end

        // A falling edge wins over a hold tick, so LONG never coincides with FALL.
        if (!level_r || accept) begin
          hold_cnt <= '0;
          held_r   <= 1'b0;
        end else if (TICK && (hold_cnt != HOLD_MAX)) begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_MAX - 1'b1) begin
            long_r <= 1'b1;
            held_r <= 1'b1;
          end
        end
      end
    end

    assign LEVEL[i] = level_r;
    assign RISE[i]  = rise_r;
    assign FALL[i]  = fall_r;
    assign LONG[i]  = long_r;
    assign HELD[i]  = held_r;
  end

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a per-cycle rule model and literal timing checks.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_input_conditioner;

  localparam int W  = 2;
  localparam int TC = 4;
  localparam int DB = 3;
  localparam int LT = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level, rise, fall, long_o, held;
  logic         tick;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(W), .TICK_CYCLES(TC), .DEBOUNCE_TICKS(DB), .LONG_TICKS(LT)
  ) dut (
    .CLK100MHZ(clk), .RST_N(rst_n), .RAW_IN(raw),
    .LEVEL(level), .RISE(rise), .FALL(fall), .LONG(long_o), .HELD(held), .TICK(tick)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Rule model: prescaler phase, two-stage input delay, tick-counted debounce and hold time.
  int           m_pre;
  logic [W-1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_long, m_held;
  int           m_dbt [W];
  int           m_hold[W];

  task automatic model_reset();
    m_pre = 0;
    m_s1 = '0; m_s2 = '0; m_level = '0;
    m_rise = '0; m_fall = '0; m_long = '0; m_held = '0;
    for (int c = 0; c < W; c++) begin
      m_dbt[c] = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic model_step();
    logic         t;
    logic [W-1:0] nlev;
    t = (m_pre == TC - 1);
    nlev = m_level;
    m_rise = '0; m_fall = '0; m_long = '0;
    for (int c = 0; c < W; c++) begin
      if (m_s2[c] == m_level[c]) begin
        m_dbt[c] = 0;
      end else if (t) begin
        m_dbt[c]++;
        if (m_dbt[c] == DB) begin
          m_dbt[c] = 0;
          nlev[c] = ~m_level[c];
          if (m_level[c]) m_fall[c] = 1'b1;
          else            m_rise[c] = 1'b1;
        end
      end
      if (m_level[c] && !nlev[c]) begin
        m_hold[c] = 0;
        m_held[c] = 1'b0;
      end else if (m_level[c] && t) begin
        m_hold[c]++;
        if (m_hold[c] == LT) m_long[c] = 1'b1;
        if (m_hold[c] >= LT) m_held[c] = 1'b1;
      end else if (!m_level[c]) begin
        m_hold[c] = 0;
      end
    end
    m_level = nlev;
    m_s2 = m_s1;
    m_s1 = raw;
    m_pre = (m_pre + 1) % TC;
  endtask

  int rise_n[W];
  int fall_n[W];
  int long_n[W];
  int tick_n = 0;
  int last_tick = -1;
  int prev_tick = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    for (int c = 0; c < W; c++) begin
      rise_n[c] = 0; fall_n[c] = 0; long_n[c] = 0;
    end
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("model_level", int'(level),  int'(m_level));
      chk("model_rise",  int'(rise),   int'(m_rise));
      chk("model_fall",  int'(fall),   int'(m_fall));
      chk("model_long",  int'(long_o), int'(m_long));
      chk("model_held",  int'(held),   int'(m_held));
      chk("model_tick",  int'(tick),   int'(m_pre == TC - 1));
      for (int c = 0; c < W; c++) begin
        if (rise[c])   rise_n[c]++;
        if (fall[c])   fall_n[c]++;
        if (long_o[c]) long_n[c]++;
      end
      if (tick) begin
        tick_n++;
        prev_tick = last_tick;
        last_tick = cyc;
      end
      if (rst_n) model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0=RISE 1=FALL 2=LONG; returns the cycle index of the negedge where all mask bits pulse.
  task automatic wait_pulse(input int which, input logic [W-1:0] m, input string name, output int at);
    logic [W-1:0] s;
    logic         found;
    found = 1'b0;
    at = -1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      s = (which == 0) ? rise : (which == 1) ? fall : long_o;
      if ((s & m) == m) begin
        found = 1'b1;
        at = cyc;
      end
    end
    chk(name, int'(found), 1);
  endtask

  int c0, at, ra, la, r0, r1, f0, l0, t0;

  initial begin
    // Reset with both inputs already high.
    rst_n = 1'b0;
    raw = 2'b11;
    step(5);
    chk("reset_outputs_zero", int'({level, rise, fall, long_o, held, tick}), 0);
    rst_n = 1'b1;
    c0 = cyc;
    wait_pulse(0, 2'b11, "reset_exit_rise_seen", at);
    chk("reset_exit_rise_latency", at - c0, 12);
    step(1);
    chk("first_ticks_last", last_tick - c0, 11);
    chk("tick_period", last_tick - prev_tick, 4);
    raw = 2'b00;
    wait_pulse(1, 2'b11, "release_both_fall_seen", at);
    step(3);

    // Clean short press on channel 0, released right after acceptance.
    r0 = rise_n[0]; r1 = rise_n[1]; f0 = fall_n[0]; l0 = long_n[0];
    raw = 2'b01;
    c0 = cyc;
    wait_pulse(0, 2'b01, "press_rise_seen", at);
    chk_range("press_latency", at - c0, 11, 14);
    chk("press_level", int'(level), 1);
    step(1);
    raw = 2'b00;
    wait_pulse(1, 2'b01, "short_release_fall_seen", at);
    step(1);
    chk("press_single_rise", rise_n[0] - r0, 1);
    chk("press_no_ch1_rise", rise_n[1] - r1, 0);
    chk("press_single_fall", fall_n[0] - f0, 1);
    chk("short_press_no_long", long_n[0] - l0, 0);
    step(4);

    // Bounce: 6 high, 2 low, 6 high, low.
    r0 = rise_n[0]; f0 = fall_n[0];
    raw = 2'b01; step(6);
    raw = 2'b00; step(2);
    raw = 2'b01; step(6);
    raw = 2'b00; step(20);
    chk("bounce_level_low", int'(level[0]), 0);
    chk("bounce_no_rise", rise_n[0] - r0, 0);
    chk("bounce_no_fall", fall_n[0] - f0, 0);

    // Long press on channel 0.
    l0 = long_n[0];
    raw = 2'b01;
    wait_pulse(0, 2'b01, "long_rise_seen", ra);
    t0 = tick_n;
    wait_pulse(2, 2'b01, "long_pulse_seen", la);
    chk("long_after_rise_cycles", la - ra, 20);
    step(1);
    chk("ticks_before_long", tick_n - t0, 5);
    chk("held_after_long", int'(held), 1);
    step(12);
    chk("single_long", long_n[0] - l0, 1);
    raw = 2'b00;
    wait_pulse(1, 2'b01, "long_release_fall_seen", at);
    chk("held_clear_with_fall", int'(held), 0);
    step(4);

    // Simultaneous rise, then reset during the hold count.
    raw = 2'b11;
    wait_pulse(0, 2'b01, "simul_rise_seen", at);
    chk("simul_rise_both", int'(rise), 3);
    step(8);
    l0 = long_n[0] + long_n[1];
    rst_n = 1'b0;
    #1;
    chk("reset_mid_hold_zero", int'({level, rise, fall, long_o, held, tick}), 0);
    step(2);
    rst_n = 1'b1;
    c0 = cyc;
    wait_pulse(0, 2'b11, "re_debounce_rise_seen", ra);
    chk("re_debounce_latency", ra - c0, 12);
    step(1);
    chk("no_long_across_reset", long_n[0] + long_n[1] - l0, 0);
    wait_pulse(2, 2'b11, "fresh_long_seen", la);
    chk("fresh_long_cycles", la - ra, 20);
    raw = 2'b00;
    wait_pulse(1, 2'b11, "final_fall_seen", at);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front end for the board's raw mechanical inputs (BTN[3:0], SW[3:0]) before they enter mest_pro_top.
- Per channel: two-flop synchronizer, tick-based debounce, one-cycle rise/fall pulses, long-press detection.
- One shared prescaler generates the debounce/hold time base, so per-channel counters stay narrow; the same RTL serves FPGA and ASIC builds.

Parameters:
- WIDTH, 8, number of independent channels (e.g. {SW, BTN}).
- TICK_CYCLES, 100000, clock cycles per time-base tick (1 ms at 100 MHz).
- DEBOUNCE_TICKS, 10, consecutive ticks an input must hold a new value before it is accepted.
- LONG_TICKS, 1000, ticks a debounced-high level must persist to flag a long press.

Ports:
- CLK100MHZ  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous active-low reset; deassertion is synchronized externally.
- RAW_IN  input  WIDTH  asynchronous raw inputs, active high.
- LEVEL  output  WIDTH  debounced level per channel.
- RISE  output  WIDTH  one-cycle pulse when LEVEL goes 0->1.
- FALL  output  WIDTH  one-cycle pulse when LEVEL goes 1->0.
- LONG  output  WIDTH  one-cycle pulse when a high level reaches LONG_TICKS.
- HELD  output  WIDTH  high from the LONG pulse until LEVEL falls.
- TICK  output  1  one-cycle time-base strobe, exported for reuse.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All outputs are 0.
  - Prescaler, sync flops, all counters and all states clear. LEVEL=0, so a channel already high at reset exit produces RISE after debounce.
  - Reset mid-debounce or mid-hold abandons the operation; no pulse is emitted.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps. TICK=1 in the cycle the count equals TICK_CYCLES-1. Counter width is clog2(TICK_CYCLES).
- Synchronizer: sync = RAW_IN delayed by two flops. Only sync feeds downstream logic.
- Per-channel debounce counter (width clog2(DEBOUNCE_TICKS+1)):
  - sync == LEVEL: counter cleared, every cycle, tick or not.
  - sync != LEVEL and TICK=1: counter increments.
  - Counter would reach DEBOUNCE_TICKS: LEVEL toggles on that clock, counter clears, and RISE or FALL pulses for exactly one cycle coincident with the new LEVEL.
  - Effective debounce window: more than (DEBOUNCE_TICKS-1)*TICK_CYCLES and at most DEBOUNCE_TICKS*TICK_CYCLES cycles after sync changes.
  - Any bounce back to LEVEL before acceptance restarts the count from 0.
- Per-channel hold counter (width clog2(LONG_TICKS+1)):
  - Active only while LEVEL=1; increments on TICK.
  - Reaching LONG_TICKS: LONG pulses one cycle, HELD is set, counter saturates. No further LONG until release.
  - LEVEL falling: counter clears and HELD clears in the same cycle FALL asserts.
  - Release before LONG_TICKS: no LONG.
  - The hold counter starts at 0 in the cycle RISE asserts. The first increment is the next TICK after that.
- Pulse exclusivity: RISE/FALL/LONG are mutually exclusive per channel per cycle. Channels are fully independent; simultaneous events on different channels all appear in the same cycle.
- Parameter limits: DEBOUNCE_TICKS >= 1, LONG_TICKS >= 1, TICK_CYCLES >= 2.

Test Plan:
Bench parameters are TICK_CYCLES=4, DEBOUNCE_TICKS=3, LONG_TICKS=5, WIDTH=2.
1. Reset and prescaler:
   - Stimulus: assert RST_N=0 with RAW_IN=2'b11, release, count TICK.
   - Required: all outputs stay 0 throughout reset. TICK pulses every 4 cycles. Both channels get RISE within 2+12 cycles of release.
2. Clean press:
   - Stimulus: RAW_IN[0] 0->1, held.
   - Required: LEVEL[0]=1 and a single RISE[0] pulse, between 2+9 and 2+12 cycles after the change. No FALL, no pulse on channel 1.
3. Bounce rejection:
   - Stimulus: RAW_IN[0] toggles high for 6 cycles, low for 2, high for 6, then low.
   - Required: LEVEL[0] stays 0, with no RISE or FALL.
4. Long press:
   - Stimulus: hold RAW_IN[0]=1 past debounce.
   - Required: one LONG[0] pulse on the 5th TICK after RISE, then HELD=1.
   - Stimulus: release.
   - Required: FALL[0] and HELD=0 in the same cycle. A press released after 3 ticks gives no LONG.
5. Simultaneous and reset mid-operation:
   - Stimulus: both channels rise together.
   - Required: RISE=2'b11 in one cycle.
   - Stimulus: pulse RST_N low during the hold count.
   - Required: all outputs 0 immediately, no LONG afterwards, and a fresh RISE after re-debounce if the inputs are still high.
